// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding and strobe decode.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package mult_pkg;

  // Controller states. The explicit encoding keeps waveforms stable across builds.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } mult_state_e;

  // Controller strobe bundle, one bit per datapath command plus status.
  typedef struct packed {
    logic load;
    logic clr;
    logic add;
    logic shift;
    logic dec;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore decode: strobes depend on the state alone, never on inputs.
  function automatic ctrl_t ctrl_decode(input mult_state_e st);
    ctrl_t c;
    c      = '0;
    c.busy = (st != ST_IDLE);
    case (st)
      ST_LOAD: begin
        c.load = 1'b1;
        c.clr  = 1'b1;
      end
      ST_ADD:   c.add = 1'b1;
      ST_SHIFT: begin
        c.shift = 1'b1;
        c.dec   = 1'b1;
      end
      ST_DONE:  c.done = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Sequencing FSM for a shift-add multiplier; the datapath (operands, accumulator, down-counter) lives outside.
// Latency: start edge to DONE entry = 2 + 2*DATA_SIZE + popcount(multiplier) cycles; done is a 1-cycle pulse.
// Backpressure: none; start is only sampled in IDLE, so requests while busy are dropped, never queued.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start                request a multiplication (honoured in IDLE only)
//   mplr_lsb             current LSB of the datapath multiplier shift register
//   count                datapath iteration down-counter value
//   load_c/load_count    load operands and counter (counter gets DATA_SIZE)
//   clr_acc, add_c       clear / accumulate into the accumulator
//   shift_c, dec_c       shift acc/multiplier pair right, decrement counter
//   busy, done           not-IDLE status, product-valid pulse
// DATA_SIZE must be at least 2 so the iteration count fits in the counter width.
module shift_add_mult_ctrl #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start,
  input  logic                 mplr_lsb,
  input  logic [DATA_SIZE-1:0] count,
  output logic                 load_c,
  output logic [DATA_SIZE-1:0] load_count,
  output logic                 clr_acc,
  output logic                 add_c,
  output logic                 shift_c,
  output logic                 dec_c,
  output logic                 busy,
  output logic                 done
);
  import mult_pkg::*;

  mult_state_e state_q;
  mult_state_e state_nxt;
  ctrl_t       ctrl_q;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_TEST;
      // Termination is tested before any shift, so the counter is never
      // decremented past zero.
      ST_TEST: begin
        if (count == '0)   state_nxt = ST_DONE;
        else if (mplr_lsb) state_nxt = ST_ADD;
        else               state_nxt = ST_SHIFT;
      end
      ST_ADD:   state_nxt = ST_SHIFT;
      ST_SHIFT: state_nxt = ST_TEST;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered alongside the state by decoding the next state,
  // so they always match the current state without a decode path on the outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= ctrl_decode(state_nxt);
    end
  end

  assign load_count = DATA_SIZE'(DATA_SIZE);
  assign load_c     = ctrl_q.load;
  assign clr_acc    = ctrl_q.clr;
  assign add_c      = ctrl_q.add;
  assign shift_c    = ctrl_q.shift;
  assign dec_c      = ctrl_q.dec;
  assign busy       = ctrl_q.busy;
  assign done       = ctrl_q.done;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: models the external datapath and checks product, latency and strobe counts.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_add_mult_ctrl;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic         start = 1'b0;
  logic         mplr_lsb;
  logic [N-1:0] count;
  logic         load_c;
  logic [N-1:0] load_count;
  logic         clr_acc, add_c, shift_c, dec_c, busy, done;

  shift_add_mult_ctrl #(.DATA_SIZE(N)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start      (start),
    .mplr_lsb   (mplr_lsb),
    .count      (count),
    .load_c     (load_c),
    .load_count (load_count),
    .clr_acc    (clr_acc),
    .add_c      (add_c),
    .shift_c    (shift_c),
    .dec_c      (dec_c),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_i = ~clk_i;

  // Datapath model: counter, multiplier shift register, accumulator.
  logic [N-1:0] a_in = '0, b_in = '0;
  logic [N-1:0] mplr_r = '0, mcand_r = '0, cnt = '0;
  logic [N:0]   acc_hi = '0;

  always @(posedge clk_i) begin
    if (load_c) begin
      mplr_r  <= a_in;
      mcand_r <= b_in;
      cnt     <= load_count;
    end
    if (clr_acc) acc_hi <= '0;
    if (add_c)   acc_hi <= acc_hi + {1'b0, mcand_r};
    if (shift_c) {acc_hi, mplr_r} <= {acc_hi, mplr_r} >> 1;
    if (dec_c)   cnt <= cnt - 1'b1;
  end

  assign mplr_lsb = mplr_r[0];
  assign count    = cnt;

  // Monitor: counts strobes of the cycle ending at each rising edge.
  int cyc = 0, n_add = 0, n_shift = 0, n_done = 0, n_viol = 0;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (add_c)   n_add   <= n_add + 1;
    if (shift_c) n_shift <= n_shift + 1;
    if (done)    n_done  <= n_done + 1;
    if ((int'(load_c) + int'(add_c) + int'(shift_c)) > 1 || (load_c && dec_c))
      n_viol <= n_viol + 1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {25'd0, load_c, clr_acc, add_c, shift_c, dec_c, busy, done};
  endfunction

  // Reference: latency and add count follow from the multiplier bit count.
  function automatic int exp_latency(input logic [N-1:0] a);
    return 2 + 2 * N + $countones(a);
  endfunction

  // Wait for done with a cycle budget, then check latency, busy and product.
  task automatic wait_done(input string tag, input int t0, input logic [N-1:0] a,
                           input logic [N-1:0] b, input bit repulse);
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk_i);
      k++;
      if (repulse) start = (k == 3 || k == 10);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_latency"}, cyc - t0, exp_latency(a));
    chk({tag, "_busy_in_done"}, busy, 1);
    chk({tag, "_product"}, {acc_hi[N-1:0], mplr_r}, 32'(a) * 32'(b));
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit repulse);
    int s_add, s_shift, s_done, s_viol, t0;
    @(negedge clk_i);
    s_add = n_add; s_shift = n_shift; s_done = n_done; s_viol = n_viol;
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    t0 = cyc;
    chk({tag, "_load"}, load_c, 1);
    wait_done(tag, t0, a, b, repulse);
    @(negedge clk_i);
    chk({tag, "_done_pulse"}, done, 0);
    @(negedge clk_i);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_adds"}, n_add - s_add, $countones(a));
    chk({tag, "_shifts"}, n_shift - s_shift, N);
    chk({tag, "_dones"}, n_done - s_done, 1);
    chk({tag, "_protocol"}, n_viol - s_viol, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, s_done, t0;
    logic [N-1:0] ra, rb;

    // Reset state
    #1 rst_ni = 1'b0;
    #1 chk("reset_outs_async", all_outs(), 0);
    repeat (3) @(negedge clk_i);
    chk("reset_outs_held", all_outs(), 0);
    chk("load_count", load_count, N);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_after_reset", all_outs(), 0);

    // Directed operations
    run_op("m05x03", 8'h05, 8'h03, 1'b0);
    run_op("m00x5a", 8'h00, 8'h5A, 1'b0);
    run_op("mffxff", 8'hFF, 8'hFF, 1'b0);
    run_op("repulse", 8'h05, 8'h03, 1'b1);

    // Asynchronous reset during ADD aborts with no done pulse
    @(negedge clk_i);
    s_done = n_done;
    a_in = 8'h05; b_in = 8'h03; start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    k = 0;
    while (!add_c && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("abort_add_seen", add_c, 1);
    #2 rst_ni = 1'b0;
    #1 chk("abort_outs_async", all_outs(), 0);
    repeat (2) @(negedge clk_i);
    chk("abort_outs_held", all_outs(), 0);
    rst_ni = 1'b1;
    repeat (30) @(negedge clk_i);
    chk("abort_no_done", n_done - s_done, 0);
    chk("abort_idle", busy, 0);
    run_op("after_abort", 8'h05, 8'h03, 1'b0);

    // Randomized operations, some with start re-pulsed while busy
    for (int i = 0; i < 10; i++) begin
      ra = N'($urandom_range(0, 255));
      rb = N'($urandom_range(0, 255));
      run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    // start held high: back-to-back operations, one IDLE cycle between them
    ra = N'($urandom_range(0, 255));
    rb = N'($urandom_range(0, 255));
    @(negedge clk_i);
    s_done = n_done;
    a_in = ra; b_in = rb; start = 1'b1;
    @(negedge clk_i);
    t0 = cyc;
    chk("b2b_load0", load_c, 1);
    for (int op = 0; op < 3; op++) begin
      start = 1'b1;
      wait_done($sformatf("b2b%0d", op), t0, ra, rb, 1'b0);
      start = 1'b1;
      @(negedge clk_i);
      chk($sformatf("b2b%0d_idle_gap", op), busy, 0);
      @(negedge clk_i);
      chk($sformatf("b2b%0d_reload", op), load_c, 1);
      t0 = cyc;
    end
    start = 1'b0;
    wait_done("b2b3", t0, ra, rb, 1'b0);
    repeat (2) @(negedge clk_i);
    chk("b2b_done_count", n_done - s_done, 4);
    chk("b2b_idle_end", busy, 0);
    chk("b2b_protocol", n_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
